// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the voice allocator: status nibbles, parser
// states and the decoded channel-message event handed to the allocator.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2,
    SKIP1,
    SKIP2
  } parser_state_t;

  typedef struct packed {
    logic [3:0] msg_type;
    logic [6:0] d1;
    logic [6:0] d2;
  } midi_event_t;

endpackage

// File: rtl/midi_msg_parser.sv
// Turns the raw MIDI byte stream into complete note-off / note-on / controller
// events for the selected channel, honouring running status for both wanted
// and skipped messages. The event is presented combinationally in the cycle
// the final data byte arrives so the allocator can register it directly.
module midi_msg_parser
  import midi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic [3:0]  rx_channel,
  output logic        ev_valid,
  output midi_event_t ev
);

  parser_state_t state;
  parser_state_t skip_entry;
  logic [3:0]    msg_type;
  logic [6:0]    d1;
  logic [3:0]    status_hi;
  logic [3:0]    status_lo;
  logic          is_tracked_type;

  assign status_hi = byte_in[7:4];
  assign status_lo = byte_in[3:0];
  assign is_tracked_type = (status_hi == NOTE_OFF) || (status_hi == NOTE_ON) || (status_hi == CC);

  // The second data byte completes the message, so it goes straight out with the latched type and d1
  always_comb begin
    ev_valid    = byte_valid && !byte_in[7] && (state == WAIT_D2);
    ev.msg_type = msg_type;
    ev.d1       = d1;
    ev.d2       = byte_in[6:0];
  end

  // Parser state machine; skip_entry remembers where running status re-enters a skipped message
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      skip_entry <= SKIP2;
      msg_type   <= '0;
      d1         <= '0;
    end else if (byte_valid) begin
      if (byte_in[7]) begin
        if (byte_in[7:3] == 5'b11111) begin
          state <= state;
        end else if (status_hi == 4'hF) begin
          state <= IDLE;
        end else if (is_tracked_type && (status_lo == rx_channel)) begin
          msg_type <= status_hi;
          state    <= WAIT_D1;
        end else if ((status_hi == PROG) || (status_hi == CHPRESS)) begin
          skip_entry <= SKIP1;
          state      <= SKIP1;
        end else begin
          skip_entry <= SKIP2;
          state      <= SKIP2;
        end
      end else begin
        case (state)
          IDLE:    state <= IDLE;
          WAIT_D1: begin
            d1    <= byte_in[6:0];
            state <= WAIT_D2;
          end
          WAIT_D2: state <= WAIT_D1;
          SKIP2:   state <= SKIP1;
          SKIP1:   state <= skip_entry;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Voice allocator: consumes parsed MIDI events and drives the voice bank's
// gate / note / velocity / trigger lines. Voices are chosen by retrigger of a
// held note, then lowest free voice, then stealing the least recently
// assigned voice as tracked by a permutation of age ranks.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  input  logic [3:0]                  rx_channel,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES-1:0][6:0]  voice_note,
  output logic [NUM_VOICES-1:0][6:0]  voice_vel,
  output logic [NUM_VOICES-1:0]       voice_trig
);

  localparam int RW = $clog2(NUM_VOICES);
  typedef logic [RW-1:0] idx_t;

  logic        ev_valid;
  midi_event_t ev;

  idx_t rank [NUM_VOICES];

  logic is_note_on;
  logic is_note_off;
  logic is_all_off;
  logic hit_found;
  logic free_found;
  idx_t hit_idx;
  idx_t free_idx;
  idx_t old_idx;
  idx_t sel_idx;

  midi_msg_parser u_parser (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .rx_channel (rx_channel),
    .ev_valid   (ev_valid),
    .ev         (ev)
  );

  // Classify the incoming event; note-on with zero velocity counts as note-off
  always_comb begin
    is_note_on  = ev_valid && (ev.msg_type == NOTE_ON) && (ev.d2 != 7'd0);
    is_note_off = ev_valid && ((ev.msg_type == NOTE_OFF) ||
                               ((ev.msg_type == NOTE_ON) && (ev.d2 == 7'd0)));
    is_all_off  = ev_valid && (ev.msg_type == CC) && (ev.d1 == CC_ALL_NOTES_OFF);
  end

  // Pick the target voice: held match first, else lowest free, else the oldest rank
  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    old_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_gate[i] && (voice_note[i] == ev.d1)) begin
        hit_found = 1'b1;
        hit_idx   = idx_t'(i);
      end
      if (!voice_gate[i]) begin
        free_found = 1'b1;
        free_idx   = idx_t'(i);
      end
      if (rank[i] == idx_t'(NUM_VOICES - 1)) begin
        old_idx = idx_t'(i);
      end
    end
    if (hit_found) begin
      sel_idx = hit_idx;
    end else if (free_found) begin
      sel_idx = free_idx;
    end else begin
      sel_idx = old_idx;
    end
  end

  // Voice registers and LRU ranks; trig is a one-cycle pulse on each assignment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      voice_gate <= '0;
      voice_note <= '0;
      voice_vel  <= '0;
      voice_trig <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        rank[i] <= idx_t'(NUM_VOICES - 1 - i);
      end
    end else begin
      voice_trig <= '0;
      if (is_note_on) begin
        voice_note[sel_idx] <= ev.d1;
        voice_vel[sel_idx]  <= ev.d2;
        voice_gate[sel_idx] <= 1'b1;
        voice_trig[sel_idx] <= 1'b1;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (rank[i] < rank[sel_idx]) begin
            rank[i] <= rank[i] + 1'b1;
          end
        end
        rank[sel_idx] <= '0;
      end else if (is_note_off) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (voice_note[i] == ev.d1) begin
            voice_gate[i] <= 1'b0;
          end
        end
      end else if (is_all_off) begin
        voice_gate <= '0;
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed testbench for midi_voice_allocator with hand-computed expectations
// for parsing, allocation, stealing, release and reset behaviour.
module tb_midi_voice_allocator;

  localparam int NV = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic [3:0]           rx_channel;
  logic [NV-1:0]        voice_gate;
  logic [NV-1:0][6:0]   voice_note;
  logic [NV-1:0][6:0]   voice_vel;
  logic [NV-1:0]        voice_trig;

  int check_count = 0;
  int pass_count  = 0;

  midi_voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .rx_channel (rx_channel),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_vel  (voice_vel),
    .voice_trig (voice_trig)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one byte for one cycle; returns at the negedge after it was consumed
  task automatic applyStimulus(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic doReset();
    byte_valid = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic any_active;
    rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    rx_channel = 4'd0;
    @(negedge clk);
    doReset();

    // Reset values and quiet period
    checkOutput("reset_gate", 32'(voice_gate), 32'h0);
    checkOutput("reset_trig", 32'(voice_trig), 32'h0);
    checkOutput("reset_note", 32'(voice_note), 32'h0);
    checkOutput("reset_vel",  32'(voice_vel),  32'h0);
    any_active = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if ((voice_gate != 0) || (voice_trig != 0) || (voice_note != 0) || (voice_vel != 0))
        any_active = 1'b1;
    end
    checkOutput("idle_100_cycles", 32'(any_active), 32'h0);

    // First note-on, then running status
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
    checkOutput("non1_gate", 32'(voice_gate), 32'h1);
    checkOutput("non1_note0", 32'(voice_note[0]), 32'h3C);
    checkOutput("non1_vel0", 32'(voice_vel[0]), 32'h64);
    checkOutput("non1_trig", 32'(voice_trig), 32'h1);
    @(negedge clk);
    checkOutput("non1_trig_drop", 32'(voice_trig), 32'h0);
    checkOutput("non1_gate_hold", 32'(voice_gate), 32'h1);

    applyStimulus(8'h40); applyStimulus(8'h50);
    checkOutput("rs_gate", 32'(voice_gate), 32'h3);
    checkOutput("rs_note1", 32'(voice_note[1]), 32'h40);
    checkOutput("rs_vel1", 32'(voice_vel[1]), 32'h50);
    checkOutput("rs_trig", 32'(voice_trig), 32'h2);
    applyStimulus(8'h3C); applyStimulus(8'h00);
    checkOutput("vel0_off_gate", 32'(voice_gate), 32'h2);
    checkOutput("vel0_off_note_kept", 32'(voice_note[0]), 32'h3C);
    checkOutput("vel0_off_trig", 32'(voice_trig), 32'h0);

    // Fill all voices back to back, then steal the oldest twice
    doReset();
    applyStimulus(8'h90);
    applyStimulus(8'h3C); applyStimulus(8'h64);
    applyStimulus(8'h3E); applyStimulus(8'h64);
    applyStimulus(8'h40); applyStimulus(8'h64);
    applyStimulus(8'h41); applyStimulus(8'h64);
    checkOutput("fill_gate", 32'(voice_gate), 32'hF);
    checkOutput("fill_trig", 32'(voice_trig), 32'h8);
    checkOutput("fill_note3", 32'(voice_note[3]), 32'h41);
    applyStimulus(8'h43); applyStimulus(8'h64);
    checkOutput("steal1_trig", 32'(voice_trig), 32'h1);
    checkOutput("steal1_note0", 32'(voice_note[0]), 32'h43);
    applyStimulus(8'h3C); applyStimulus(8'h64);
    checkOutput("steal2_trig", 32'(voice_trig), 32'h2);
    checkOutput("steal2_note1", 32'(voice_note[1]), 32'h3C);
    checkOutput("steal2_gate", 32'(voice_gate), 32'hF);
    applyStimulus(8'h40); applyStimulus(8'h7F);
    checkOutput("retrig_trig", 32'(voice_trig), 32'h4);
    checkOutput("retrig_vel2", 32'(voice_vel[2]), 32'h7F);
    checkOutput("retrig_gate", 32'(voice_gate), 32'hF);
    applyStimulus(8'h80); applyStimulus(8'h43); applyStimulus(8'h00);
    checkOutput("noteoff_gate", 32'(voice_gate), 32'hE);
    applyStimulus(8'h55); applyStimulus(8'h00);
    checkOutput("noteoff_nomatch_gate", 32'(voice_gate), 32'hE);
    applyStimulus(8'h90); applyStimulus(8'h30); applyStimulus(8'h20);
    checkOutput("free_after_off_trig", 32'(voice_trig), 32'h1);
    checkOutput("free_after_off_note0", 32'(voice_note[0]), 32'h30);

    // Real-time byte mid-message, foreign channel, skipped messages, sysex
    doReset();
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'hF8); applyStimulus(8'h64);
    checkOutput("rt_gate", 32'(voice_gate), 32'h1);
    checkOutput("rt_vel0", 32'(voice_vel[0]), 32'h64);
    applyStimulus(8'h91); applyStimulus(8'h30); applyStimulus(8'h40);
    applyStimulus(8'h31); applyStimulus(8'h41);
    checkOutput("other_ch_gate", 32'(voice_gate), 32'h1);
    checkOutput("other_ch_note1", 32'(voice_note[1]), 32'h0);
    applyStimulus(8'hC0); applyStimulus(8'h05); applyStimulus(8'h06);
    applyStimulus(8'h90); applyStimulus(8'h3E); applyStimulus(8'h22);
    checkOutput("after_prog_gate", 32'(voice_gate), 32'h3);
    checkOutput("after_prog_note1", 32'(voice_note[1]), 32'h3E);
    checkOutput("after_prog_vel1", 32'(voice_vel[1]), 32'h22);
    rx_channel = 4'd5;
    applyStimulus(8'h40); applyStimulus(8'h11);
    checkOutput("ch_latched_gate", 32'(voice_gate), 32'h7);
    rx_channel = 4'd0;
    applyStimulus(8'hF0); applyStimulus(8'h41); applyStimulus(8'h12);
    checkOutput("sysex_drop_gate", 32'(voice_gate), 32'h7);
    checkOutput("sysex_drop_trig", 32'(voice_trig), 32'h0);

    // Controllers: unrelated CC ignored, all-notes-off clears gates only
    doReset();
    applyStimulus(8'h90);
    applyStimulus(8'h3C); applyStimulus(8'h64);
    applyStimulus(8'h3E); applyStimulus(8'h64);
    applyStimulus(8'h40); applyStimulus(8'h64);
    applyStimulus(8'h41); applyStimulus(8'h64);
    applyStimulus(8'hB0); applyStimulus(8'h07); applyStimulus(8'h64);
    checkOutput("cc_other_gate", 32'(voice_gate), 32'hF);
    applyStimulus(8'h7B); applyStimulus(8'h00);
    checkOutput("all_off_gate", 32'(voice_gate), 32'h0);
    checkOutput("all_off_note3", 32'(voice_note[3]), 32'h41);

    // Reset in the middle of a message discards it
    applyStimulus(8'h90); applyStimulus(8'h3C);
    doReset();
    applyStimulus(8'h50); applyStimulus(8'h60);
    checkOutput("rst_mid_gate", 32'(voice_gate), 32'h0);
    checkOutput("rst_mid_trig", 32'(voice_trig), 32'h0);
    checkOutput("rst_mid_note0", 32'(voice_note[0]), 32'h0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
